// File: rtl/exm_pipe_reg_if.sv
// rtl/exm_pipe_reg_if.sv - EX/MEM pipeline register signal bundle
// Forwarding-unit signals exist only when EXM_FWD_EN is defined.
interface exm_pipe_reg_if #(
   parameter int DATA_W  = 16,
   parameter int REG_W   = 4,
   parameter int MOVOP_W = 4
);
   logic               stall_ex;
   logic               flush_ex;
   logic               valid_in;
   logic [DATA_W-1:0]  alu_result_in;
   logic [DATA_W-1:0]  alu_remainder_in;
   logic [MOVOP_W-1:0] movop_in;
   logic [REG_W-1:0]   regrd_in;
   logic               memtoreg_in;
   logic               memwrite_in;
   logic               memread_in;
   logic               r15_in;
   logic               regwrite_in;
   logic [REG_W-1:0]   id_rs_a;
   logic [REG_W-1:0]   id_rs_b;

   logic               valid_out;
   logic [DATA_W-1:0]  alu_result_out;
   logic [DATA_W-1:0]  alu_remainder_out;
   logic [MOVOP_W-1:0] movop_out;
   logic [REG_W-1:0]   regrd_out;
   logic               memtoreg_out;
   logic               memwrite_out;
   logic               memread_out;
   logic               r15_out;
   logic               regwrite_out;
   logic               load_use_hazard;

`ifdef EXM_FWD_EN
   logic [REG_W-1:0]   ex_rs_a;
   logic [REG_W-1:0]   ex_rs_b;
   logic               fwd_a;
   logic               fwd_b;
   logic [DATA_W-1:0]  fwd_data_a;
   logic [DATA_W-1:0]  fwd_data_b;
`endif

   modport master (
`ifdef EXM_FWD_EN
      output ex_rs_a, ex_rs_b,
      input  fwd_a, fwd_b, fwd_data_a, fwd_data_b,
`endif
      output stall_ex, flush_ex, valid_in, alu_result_in, alu_remainder_in, movop_in,
             regrd_in, memtoreg_in, memwrite_in, memread_in, r15_in, regwrite_in,
             id_rs_a, id_rs_b,
      input  valid_out, alu_result_out, alu_remainder_out, movop_out, regrd_out,
             memtoreg_out, memwrite_out, memread_out, r15_out, regwrite_out,
             load_use_hazard
   );

   modport slave (
`ifdef EXM_FWD_EN
      input  ex_rs_a, ex_rs_b,
      output fwd_a, fwd_b, fwd_data_a, fwd_data_b,
`endif
      input  stall_ex, flush_ex, valid_in, alu_result_in, alu_remainder_in, movop_in,
             regrd_in, memtoreg_in, memwrite_in, memread_in, r15_in, regwrite_in,
             id_rs_a, id_rs_b,
      output valid_out, alu_result_out, alu_remainder_out, movop_out, regrd_out,
             memtoreg_out, memwrite_out, memread_out, r15_out, regwrite_out,
             load_use_hazard
   );
endinterface

// File: rtl/exm_pipe_reg.sv
// rtl/exm_pipe_reg.sv - EX/MEM pipeline register with stall, flush-to-bubble and load-use detect
// Define EXM_FWD_EN to add the EX-stage forwarding compare and data select.
module exm_pipe_reg #(
   parameter int DATA_W  = 16,
   parameter int REG_W   = 4,
   parameter int MOVOP_W = 4
) (
   input logic           clk,
   input logic           rst_n,
   exm_pipe_reg_if.slave bus
);
   logic               validQ;
   logic [DATA_W-1:0]  resultQ;
   logic [DATA_W-1:0]  remQ;
   logic [MOVOP_W-1:0] movopQ;
   logic [REG_W-1:0]   regrdQ;
   logic               memToRegQ;
   logic               memWriteQ;
   logic               memReadQ;
   logic               r15Q;
   logic               regWriteQ;

   // Flush beats stall; a non-valid capture keeps its data but never its control bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || bus.flush_ex) begin
         validQ    <= 1'b0;
         resultQ   <= '0;
         remQ      <= '0;
         movopQ    <= '0;
         regrdQ    <= '0;
         memToRegQ <= 1'b0;
         memWriteQ <= 1'b0;
         memReadQ  <= 1'b0;
         r15Q      <= 1'b0;
         regWriteQ <= 1'b0;
      end else if (!bus.stall_ex) begin
         validQ    <= bus.valid_in;
         resultQ   <= bus.alu_result_in;
         remQ      <= bus.alu_remainder_in;
         movopQ    <= bus.movop_in;
         regrdQ    <= bus.regrd_in;
         memToRegQ <= bus.valid_in & bus.memtoreg_in;
         memWriteQ <= bus.valid_in & bus.memwrite_in;
         memReadQ  <= bus.valid_in & bus.memread_in;
         r15Q      <= bus.valid_in & bus.r15_in;
         regWriteQ <= bus.valid_in & bus.regwrite_in;
      end
   end

   assign bus.valid_out         = validQ;
   assign bus.alu_result_out    = resultQ;
   assign bus.alu_remainder_out = remQ;
   assign bus.movop_out         = movopQ;
   assign bus.regrd_out         = regrdQ;
   assign bus.memtoreg_out      = memToRegQ;
   assign bus.memwrite_out      = memWriteQ;
   assign bus.memread_out       = memReadQ;
   assign bus.r15_out           = r15Q;
   assign bus.regwrite_out      = regWriteQ;

   assign bus.load_use_hazard = validQ & memReadQ & regWriteQ &
                                ((regrdQ == bus.id_rs_a) | (regrdQ == bus.id_rs_b));

`ifdef EXM_FWD_EN
   logic aluWrites;
   logic remHitA;
   logic remHitB;

   // R15 receives the remainder, so a read of the all-ones register forwards remQ.
   assign aluWrites = validQ & regWriteQ & ~memReadQ;
   assign remHitA   = aluWrites & r15Q & (&bus.ex_rs_a);
   assign remHitB   = aluWrites & r15Q & (&bus.ex_rs_b);

   assign bus.fwd_a      = (aluWrites & (regrdQ == bus.ex_rs_a)) | remHitA;
   assign bus.fwd_b      = (aluWrites & (regrdQ == bus.ex_rs_b)) | remHitB;
   assign bus.fwd_data_a = remHitA ? remQ : resultQ;
   assign bus.fwd_data_b = remHitB ? remQ : resultQ;
`endif
endmodule

// File: tb/tb_exm_pipe_reg.sv
// tb/tb_exm_pipe_reg.sv - self-checking bench for exm_pipe_reg against a behavioural model
module tb_exm_pipe_reg;
   localparam int DATA_W  = 16;
   localparam int REG_W   = 4;
   localparam int MOVOP_W = 4;
   localparam int VW      = 2*DATA_W + MOVOP_W + REG_W + 7;

   logic clk;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   exm_pipe_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .MOVOP_W(MOVOP_W)) bus();

   exm_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .MOVOP_W(MOVOP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: what the MEM stage should currently be seeing.
   logic               mValid;
   logic [DATA_W-1:0]  mResult;
   logic [DATA_W-1:0]  mRem;
   logic [MOVOP_W-1:0] mMovop;
   logic [REG_W-1:0]   mRegrd;
   logic [4:0]         mCtrl;   // {memtoreg, memwrite, memread, r15, regwrite}

   logic [VW-1:0] obsVec;
   assign obsVec = {bus.valid_out, bus.alu_result_out, bus.alu_remainder_out, bus.movop_out,
                    bus.regrd_out, bus.memtoreg_out, bus.memwrite_out, bus.memread_out,
                    bus.r15_out, bus.regwrite_out, bus.load_use_hazard};

   function automatic logic [VW-1:0] expVec();
      logic hz;
      hz = mValid && mCtrl[2] && mCtrl[0] && (mRegrd == bus.id_rs_a || mRegrd == bus.id_rs_b);
      return {mValid, mResult, mRem, mMovop, mRegrd, mCtrl, hz};
   endfunction

`ifdef EXM_FWD_EN
   function automatic logic [DATA_W:0] expFwd(input logic [REG_W-1:0] rs);
      logic remSel;
      logic hit;
      remSel = mCtrl[1] && (rs == {REG_W{1'b1}});
      hit    = mValid && mCtrl[0] && !mCtrl[2] && (mRegrd == rs || remSel);
      return {hit, remSel ? mRem : mResult};
   endfunction
`endif

   task automatic modelClear();
      mValid = 0; mResult = '0; mRem = '0; mMovop = '0; mRegrd = '0; mCtrl = '0;
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] r, input logic [DATA_W-1:0] rm,
                        input logic [MOVOP_W-1:0] mo, input logic [REG_W-1:0] rd,
                        input logic [4:0] ctrl);
      bus.valid_in = v; bus.alu_result_in = r; bus.alu_remainder_in = rm;
      bus.movop_in = mo; bus.regrd_in = rd;
      {bus.memtoreg_in, bus.memwrite_in, bus.memread_in, bus.r15_in, bus.regwrite_in} = ctrl;
   endtask

   // Advance the model by the rules for one edge, then let the DUT take that edge.
   task automatic tick();
      if (bus.flush_ex) modelClear();
      else if (!bus.stall_ex) begin
         mValid  = bus.valid_in;
         mResult = bus.alu_result_in;
         mRem    = bus.alu_remainder_in;
         mMovop  = bus.movop_in;
         mRegrd  = bus.regrd_in;
         mCtrl   = bus.valid_in ? {bus.memtoreg_in, bus.memwrite_in, bus.memread_in,
                                   bus.r15_in, bus.regwrite_in} : 5'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      modelClear();
      drive(1, 16'hAAAA, 16'h5555, 4'h9, 4'h3, 5'b11111);
      #3;
      total++;
      if (obsVec !== expVec()) $display("FAIL reset_async got %h exp %h", obsVec, expVec());
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (obsVec !== expVec()) $display("FAIL reset_hold got %h exp %h", obsVec, expVec());
      else passed++;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_capture();
      drive(1, 16'h000F, 16'h000C, 4'd3, 4'd5, 5'b11111);
      tick();
      total++;
      if (obsVec !== expVec() || bus.valid_out !== 1'b1)
         $display("FAIL capture got %h exp %h", obsVec, expVec());
      else passed++;
   endtask

   task automatic test_flush();
      drive(1, 16'h000F, 16'h000C, 4'd3, 4'd5, 5'b11111);
      bus.flush_ex = 1;
      tick();
      total++;
      if (obsVec !== expVec()) $display("FAIL flush_bubble got %h exp %h", obsVec, expVec());
      else passed++;
      bus.flush_ex = 0;
      drive(1, 16'd6, 16'd8, 4'd5, 4'hC, 5'b01101);
      tick();
      total++;
      if (obsVec !== expVec()) $display("FAIL flush_recover got %h exp %h", obsVec, expVec());
      else passed++;
   endtask

   task automatic test_stall();
      drive(1, 16'h1234, 16'h0001, 4'd1, 4'd2, 5'b00001);
      tick();
      bus.stall_ex = 1;
      for (int i = 0; i < 3; i++) begin
         drive(1, DATA_W'($urandom), DATA_W'($urandom), MOVOP_W'($urandom), REG_W'($urandom), 5'b11111);
         tick();
         total++;
         if (obsVec !== expVec() || bus.alu_result_out !== 16'h1234)
            $display("FAIL stall_hold%0d got %h exp %h", i, obsVec, expVec());
         else passed++;
      end
      bus.flush_ex = 1;
      tick();
      total++;
      if (obsVec !== expVec()) $display("FAIL stall_flush got %h exp %h", obsVec, expVec());
      else passed++;
      bus.flush_ex = 0;
      bus.stall_ex = 0;
   endtask

   task automatic test_async_reset();
      drive(1, 16'hCAFE, 16'h00FF, 4'd7, 4'd9, 5'b00001);
      tick();
      bus.stall_ex = 1;
      #2;
      rst_n = 0;
      #1;
      modelClear();
      total++;
      if (obsVec !== expVec()) $display("FAIL async_reset got %h exp %h", obsVec, expVec());
      else passed++;
      #1;
      rst_n = 1;
      bus.stall_ex = 0;
   endtask

   task automatic test_load_use();
      bus.id_rs_a = 4'd0;
      bus.id_rs_b = 4'd0;
      drive(1, 16'h0100, 16'h0000, 4'd0, 4'd7, 5'b00101);
      tick();
      bus.id_rs_b = 4'd7;
      #1;
      total++;
      if (obsVec !== expVec() || bus.load_use_hazard !== 1'b1)
         $display("FAIL load_use_hit got %h exp %h", obsVec, expVec());
      else passed++;
      bus.id_rs_a = 4'd3;
      bus.id_rs_b = 4'd3;
      #1;
      total++;
      if (obsVec !== expVec() || bus.load_use_hazard !== 1'b0)
         $display("FAIL load_use_miss got %h exp %h", obsVec, expVec());
      else passed++;
      drive(0, 16'h0100, 16'h0000, 4'd0, 4'd7, 5'b00101);
      bus.id_rs_b = 4'd7;
      tick();
      total++;
      if (obsVec !== expVec() || bus.load_use_hazard !== 1'b0)
         $display("FAIL load_use_invalid got %h exp %h", obsVec, expVec());
      else passed++;
   endtask

`ifdef EXM_FWD_EN
   task automatic test_forward();
      drive(1, 16'hBEEF, 16'h0000, 4'd0, 4'd2, 5'b00001);
      bus.ex_rs_a = 4'd2;
      bus.ex_rs_b = 4'd0;
      tick();
      total++;
      if ({bus.fwd_a, bus.fwd_data_a} !== expFwd(bus.ex_rs_a) || bus.fwd_data_a !== 16'hBEEF)
         $display("FAIL fwd_a got %h exp %h", {bus.fwd_a, bus.fwd_data_a}, expFwd(bus.ex_rs_a));
      else passed++;
      drive(1, 16'hBEEF, 16'h0042, 4'd0, 4'd2, 5'b00011);
      bus.ex_rs_b = 4'hF;
      tick();
      total++;
      if ({bus.fwd_b, bus.fwd_data_b} !== expFwd(bus.ex_rs_b) || bus.fwd_data_b !== 16'h0042)
         $display("FAIL fwd_b_r15 got %h exp %h", {bus.fwd_b, bus.fwd_data_b}, expFwd(bus.ex_rs_b));
      else passed++;
   endtask
`endif

   task automatic test_random();
      logic [4:0] ctrl;
      for (int i = 0; i < 300; i++) begin
         ctrl = 5'($urandom);
         if (ctrl[1]) ctrl[0] = 1'b1;
         drive(1'($urandom), DATA_W'($urandom), DATA_W'($urandom), MOVOP_W'($urandom),
               REG_W'($urandom), ctrl);
         bus.stall_ex = ($urandom_range(0, 4) == 0);
         bus.flush_ex = ($urandom_range(0, 9) == 0);
         bus.id_rs_a  = ($urandom_range(0, 2) == 0) ? bus.regrd_in : REG_W'($urandom);
         bus.id_rs_b  = REG_W'($urandom);
`ifdef EXM_FWD_EN
         bus.ex_rs_a  = ($urandom_range(0, 1) == 0) ? bus.regrd_in : REG_W'($urandom);
         bus.ex_rs_b  = ($urandom_range(0, 2) == 0) ? {REG_W{1'b1}} : REG_W'($urandom);
`endif
         tick();
         total++;
         if (obsVec !== expVec()) $display("FAIL random%0d got %h exp %h", i, obsVec, expVec());
         else passed++;
`ifdef EXM_FWD_EN
         total++;
         if ({bus.fwd_a, bus.fwd_data_a, bus.fwd_b, bus.fwd_data_b} !==
             {expFwd(bus.ex_rs_a), expFwd(bus.ex_rs_b)})
            $display("FAIL random_fwd%0d got %h exp %h", i,
                     {bus.fwd_a, bus.fwd_data_a, bus.fwd_b, bus.fwd_data_b},
                     {expFwd(bus.ex_rs_a), expFwd(bus.ex_rs_b)});
         else passed++;
`endif
      end
      bus.stall_ex = 0;
      bus.flush_ex = 0;
   endtask

   initial begin
      rst_n = 0;
      bus.stall_ex = 0;
      bus.flush_ex = 0;
      bus.id_rs_a  = '0;
      bus.id_rs_b  = '0;
`ifdef EXM_FWD_EN
      bus.ex_rs_a  = '0;
      bus.ex_rs_b  = '0;
`endif
      test_reset();
      test_capture();
      test_flush();
      test_stall();
      test_async_reset();
      test_load_use();
`ifdef EXM_FWD_EN
      test_forward();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
